// File: rtl/pic_demo.sv
// Minimal PIC16-flavoured 8-bit core: executes one instruction per enabled clock
// straight from ui_in, with W, a 16-entry register file (PORT/TRIS/STATUS/RAM) and Z/C.
module pic_demo (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] F_PORT   = 4'd0;
  localparam logic [3:0] F_TRIS   = 4'd1;
  localparam logic [3:0] F_STATUS = 4'd2;

  logic [7:0] w_q;
  logic [7:0] port_q;
  logic [7:0] tris_q;
  logic       z_q;
  logic       c_q;
  logic [7:0] ram_q [0:15];

  logic [3:0] opcode;
  logic [3:0] f;
  logic [7:0] rf_rd;
  logic [8:0] sum;
  logic [8:0] diff;

  logic [7:0] w_nxt;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       z_upd;
  logic       c_upd;
  logic       c_val;
  logic       z_val;
  logic       z_nxt;
  logic       c_nxt;

  assign opcode = ui_in[7:4];
  assign f      = ui_in[3:0];

  // PORT reads the pins, not the latch, so RMW on f=0 reads pins and writes the latch.
  always_comb begin
    rf_rd = 8'h00;
    case (f)
      F_PORT:   rf_rd = uio_in;
      F_TRIS:   rf_rd = tris_q;
      F_STATUS: rf_rd = {6'b0, z_q, c_q};
      default:  rf_rd = ram_q[f];
    endcase
  end

  assign sum  = {1'b0, w_q} + {1'b0, rf_rd};
  assign diff = {1'b0, rf_rd} - {1'b0, w_q};

  always_comb begin
    w_nxt   = w_q;
    wr_en   = 1'b0;
    wr_data = rf_rd;
    z_upd   = 1'b0;
    c_upd   = 1'b0;
    c_val   = c_q;
    case (opcode)
      4'h1: w_nxt = {4'h0, f};
      4'h2: w_nxt = {f, w_q[3:0]};
      4'h3: begin wr_en = 1'b1; wr_data = w_q; end
      4'h4: begin w_nxt = rf_rd; z_upd = 1'b1; end
      4'h5: begin w_nxt = sum[7:0]; z_upd = 1'b1; c_upd = 1'b1; c_val = sum[8]; end
      4'h6: begin w_nxt = diff[7:0]; z_upd = 1'b1; c_upd = 1'b1; c_val = ~diff[8]; end
      4'h7: begin w_nxt = w_q & rf_rd; z_upd = 1'b1; end
      4'h8: begin w_nxt = w_q | rf_rd; z_upd = 1'b1; end
      4'h9: begin w_nxt = w_q ^ rf_rd; z_upd = 1'b1; end
      4'hA: begin wr_en = 1'b1; wr_data = rf_rd + 8'd1; z_upd = 1'b1; end
      4'hB: begin wr_en = 1'b1; wr_data = rf_rd - 8'd1; z_upd = 1'b1; end
      4'hC: begin
        wr_en = 1'b1; wr_data = {rf_rd[6:0], c_q}; c_upd = 1'b1; c_val = rf_rd[7];
      end
      4'hD: begin
        wr_en = 1'b1; wr_data = {c_q, rf_rd[7:1]}; c_upd = 1'b1; c_val = rf_rd[0];
      end
      4'hE: begin wr_en = 1'b1; wr_data = 8'h00; z_upd = 1'b1; end
      4'hF: begin w_nxt = 8'h00; z_upd = 1'b1; end
      default: ;
    endcase
  end

  // Z tracks whichever destination the instruction writes.
  assign z_val = wr_en ? (wr_data == 8'h00) : (w_nxt == 8'h00);

  // A write to STATUS loads each flag unless the instruction computes that flag itself.
  always_comb begin
    z_nxt = z_q;
    c_nxt = c_q;
    if (wr_en && f == F_STATUS) begin
      z_nxt = wr_data[1];
      c_nxt = wr_data[0];
    end
    if (z_upd) z_nxt = z_val;
    if (c_upd) c_nxt = c_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= 8'h00;
      port_q <= 8'h00;
      tris_q <= 8'hFF;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
    end else if (ena) begin
      w_q <= w_nxt;
      z_q <= z_nxt;
      c_q <= c_nxt;
      if (wr_en) begin
        case (f)
          F_PORT:   port_q <= wr_data;
          F_TRIS:   tris_q <= wr_data;
          F_STATUS: ;
          default:  ram_q[f] <= wr_data;
        endcase
      end
    end
  end

  assign uo_out  = w_q;
  assign uio_out = port_q;
  assign uio_oe  = ~tris_q;

endmodule

// File: tb/tb_pic_demo.sv
// Directed-vector bench for pic_demo: each step applies one instruction and
// compares the registered outputs against hand-computed values.
module tb_pic_demo;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  pic_demo dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one instruction across one rising edge, settle 1 time unit after
  task automatic exec(input logic [7:0] ins);
    ui_in = ins;
    ena   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] ins);
    ui_in = ins;
    ena   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h1F;
    uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w", uo_out, 8'h00);
    chk("rst_port", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'h00);
    rst = 1'b0;
    exec(8'h00);
    chk("nop_w", uo_out, 8'h00);
    chk("nop_oe", uio_oe, 8'h00);

    // literals
    exec(8'h15); chk("movlw", uo_out, 8'h05);
    exec(8'h2A); chk("movlwh", uo_out, 8'hA5);

    // add with carry
    exec(8'h10); exec(8'h2F); chk("w_f0", uo_out, 8'hF0);
    exec(8'h33); exec(8'h53); chk("addwf", uo_out, 8'hE0);
    exec(8'h42); chk("status_add", uo_out, 8'h01);

    // subtract to zero
    exec(8'h17); exec(8'h34); exec(8'h64); chk("subwf_zero", uo_out, 8'h00);
    exec(8'h42); chk("status_sub", uo_out, 8'h03);

    // GPIO
    exec(8'hE1); chk("clrf_tris", uio_oe, 8'hFF);
    exec(8'h1C); exec(8'h23); exec(8'h30); chk("port_latch", uio_out, 8'h3C);
    uio_in = 8'h5A;
    exec(8'h40); chk("port_read", uo_out, 8'h5A);

    // hold
    idle(8'h1F); idle(8'h1F); idle(8'h1F);
    chk("hold_w", uo_out, 8'h5A);
    chk("hold_port", uio_out, 8'h3C);

    // rotate with C cleared via CLRF STATUS
    exec(8'hE2); exec(8'h35); exec(8'hF0); chk("clrw", uo_out, 8'h00);
    exec(8'hC5); exec(8'h45); chk("rlf", uo_out, 8'hB4);
    exec(8'hD5); exec(8'h45); chk("rrf", uo_out, 8'h5A);

    // decrement wrap / increment wrap
    exec(8'hB6); exec(8'h46); chk("decf_wrap", uo_out, 8'hFF);
    exec(8'hA6); exec(8'h42); chk("incf_wrap_z", uo_out, 8'h02);

    // STATUS write via MOVWF
    exec(8'h13); exec(8'h32); exec(8'h42); chk("status_write", uo_out, 8'h03);

    // logic ops against RAM7=0x0C
    exec(8'h1C); exec(8'h37);
    exec(8'h13); exec(8'h77); chk("andwf", uo_out, 8'h00);
    exec(8'h13); exec(8'h87); chk("iorwf", uo_out, 8'h0F);
    exec(8'h97); chk("xorwf", uo_out, 8'h03);

    // subtract with borrow: 0x0C - 0x0D
    exec(8'h1D); exec(8'h67); chk("subwf_borrow", uo_out, 8'hFF);
    exec(8'h42); chk("status_borrow", uo_out, 8'h00);

    // reset dominates ena=0
    exec(8'h1C); exec(8'h30);
    rst = 1'b1;
    idle(8'h1F);
    chk("rst2_w", uo_out, 8'h00);
    chk("rst2_port", uio_out, 8'h00);
    chk("rst2_oe", uio_oe, 8'h00);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
